// File: rtl/pusch_rx_pkg.sv
// Shared types and helpers for the PUSCH receive chain: FSM states, Gold
// sequence constants and the scrambler seed calculation.
package pusch_rx_pkg;

  typedef enum logic [1:0] {IDLE, WARM, RUN, FIN} state_t;

  localparam int NC_DEFAULT = 1600;
  localparam int LFSR_W     = 31;

  // Scrambler seed; msgA carries n_RAPID and shifts n_RNTI up one extra bit,
  // so bit 15 of n_RNTI falls off the 31-bit seed in that case.
  function automatic logic [LFSR_W-1:0] calc_c_init(input logic        cfg,
                                                    input logic [15:0] rnti,
                                                    input logic [5:0]  rapid,
                                                    input logic [9:0]  cell_id);
    if (cfg)
      return {rnti[14:0], 16'h0} + {15'h0, rapid, 10'h0} + {21'h0, cell_id};
    else
      return {rnti, 15'h0} + {21'h0, cell_id};
  endfunction

endpackage

// File: rtl/pusch_gold_gen.sv
// Length-31 Gold sequence generator (x1/x2 LFSR pair); bit 0 of each register
// holds x(n), so c(n) is available combinationally at the current position.
module pusch_gold_gen
  import pusch_rx_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [LFSR_W-1:0] c_init,
  input  logic              advance,
  output logic              c
);

  logic [LFSR_W-1:0] x1, x2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x1 <= '0;
      x2 <= '0;
    end else if (load) begin
      x1 <= LFSR_W'(1);
      x2 <= c_init;
    end else if (advance) begin
      x1 <= {x1[3] ^ x1[0], x1[LFSR_W-1:1]};
      x2 <= {x2[3] ^ x2[2] ^ x2[1] ^ x2[0], x2[LFSR_W-1:1]};
    end
  end

  assign c = x1[0] ^ x2[0];

endmodule

// File: rtl/pusch_llr_descrambler.sv
// PUSCH receive descrambler: flips the sign of each soft bit where the Gold
// sequence is 1, streaming one codeword of G LLRs per start pulse.
module pusch_llr_descrambler
  import pusch_rx_pkg::*;
#(
  parameter int LLR_W = 8,
  parameter int NC    = NC_DEFAULT,
  parameter int G_W   = 17
)(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [15:0]             N_Rnti,
  input  logic [9:0]              N_cell_ID,
  input  logic [5:0]              N_Rapid,
  input  logic                    Config,
  input  logic [G_W-1:0]          num_bits,
  input  logic signed [LLR_W-1:0] LLR_in,
  input  logic                    LLR_valid_in,
  output logic                    LLR_ready_out,
  output logic signed [LLR_W-1:0] LLR_out,
  output logic                    LLR_valid_out,
  input  logic                    LLR_ready_in,
  output logic                    busy,
  output logic                    done
);

  localparam int WC_W = $clog2(NC + 1);
  localparam logic signed [LLR_W-1:0] LLR_MAX = {1'b0, {(LLR_W-1){1'b1}}};
  localparam logic signed [LLR_W-1:0] LLR_MIN = {1'b1, {(LLR_W-1){1'b0}}};

  state_t                  state;
  logic [G_W-1:0]          g_len;
  logic [G_W-1:0]          acc_cnt;
  logic [WC_W-1:0]         warm_cnt;
  logic [LFSR_W-1:0]       c_init;
  logic                    c, load, advance, accept, drain;
  logic signed [LLR_W-1:0] llr_neg;

  assign c_init        = calc_c_init(Config, N_Rnti, N_Rapid, N_cell_ID);
  assign load          = (state == IDLE) && start;
  assign LLR_ready_out = (state == RUN) && (!LLR_valid_out || LLR_ready_in);
  assign accept        = LLR_valid_in && LLR_ready_out;
  assign drain         = LLR_valid_out && LLR_ready_in;
  // Sequence position moves only on warm-up or on an accepted LLR.
  assign advance       = (state == WARM) || accept;
  assign busy          = (state != IDLE);
  // Negating the most negative code would wrap; clamp to the positive max.
  assign llr_neg       = (LLR_in == LLR_MIN) ? LLR_MAX : -LLR_in;

  pusch_gold_gen u_gold (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .c_init  (c_init),
    .advance (advance),
    .c       (c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      g_len    <= '0;
      acc_cnt  <= '0;
      warm_cnt <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          g_len    <= num_bits;
          acc_cnt  <= '0;
          warm_cnt <= '0;
          state    <= WARM;
        end
        WARM: begin
          warm_cnt <= warm_cnt + 1'b1;
          if (warm_cnt == WC_W'(NC - 1))
            state <= (g_len == '0) ? FIN : RUN;
        end
        RUN: if (accept) begin
          acc_cnt <= acc_cnt + 1'b1;
          if (acc_cnt == g_len - 1'b1)
            state <= FIN;
        end
        FIN: if (!LLR_valid_out || LLR_ready_in) begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Single output register: reload on accept, otherwise empty on drain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      LLR_out       <= '0;
      LLR_valid_out <= 1'b0;
    end else if (accept) begin
      LLR_out       <= c ? llr_neg : LLR_in;
      LLR_valid_out <= 1'b1;
    end else if (drain) begin
      LLR_valid_out <= 1'b0;
    end
  end

endmodule
